// File: rtl/addsub_pipe_param.sv
// -----------------------------------------------------------------------------
// addsub_pipe_param
//
// Pipelined, carry-chained adder/subtractor. The operands are cut into
// NUM_STG slices of STG_WIDTH bits. Stage k adds slice k of the operands plus
// the registered carry out of stage k-1. Operand slices that are not yet
// consumed and sum slices that are already finished travel alongside in
// registers, so each sample moves through the pipeline as one self-contained
// bundle. Samples never share a carry.
//
// Subtraction is computed as A + ~B + 1: B is inverted on entry and the
// stage-0 carry-in is the mode bit. The final carry is inverted on the way
// out, so the result MSB reads as a borrow (1 iff adda < addb).
//
// Parameters
//   DATA_WIDTH  operand width in bits
//   STG_WIDTH   bits added per pipeline stage (NUM_STG = DATA_WIDTH/STG_WIDTH)
//
// Ports
//   clk      rising-edge clock for all state
//   rst_n    asynchronous active-low reset; clears every pipeline register
//   i_en     input sample valid
//   i_sub    per-sample mode: 0 = add, 1 = subtract
//   i_stall  freeze the whole pipeline this cycle (takes priority over i_en)
//   adda     operand A, unsigned
//   addb     operand B, unsigned
//   result   registered {carry/borrow, sum}; value is don't-care when !o_en
//   o_en     registered result valid, NUM_STG enabled edges after capture
// -----------------------------------------------------------------------------
module addsub_pipe_param #(
  parameter int DATA_WIDTH = 64,
  parameter int STG_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_en,
  input  logic                  i_sub,
  input  logic                  i_stall,
  input  logic [DATA_WIDTH-1:0] adda,
  input  logic [DATA_WIDTH-1:0] addb,
  output logic [DATA_WIDTH:0]   result,
  output logic                  o_en
);

  localparam int NUM_STG = DATA_WIDTH / STG_WIDTH;

  if (((DATA_WIDTH % STG_WIDTH) != 0) || (NUM_STG < 2)) begin : g_param_check
    $error("addsub_pipe_param: DATA_WIDTH must be a multiple of STG_WIDTH giving at least 2 stages");
  end

  for (genvar k = 0; k < NUM_STG; k++) begin : g_stg
    // Width of the still-unconsumed B operand arriving at this stage; the
    // slice this stage adds sits in its low STG_WIDTH bits.
    localparam int IW   = DATA_WIDTH - k * STG_WIDTH;
    localparam bit LAST = (k == NUM_STG - 1);

    // as_* holds finished sum slices below slice k and untouched A slices
    // from slice k upward, so one register carries both without waste.
    logic [DATA_WIDTH-1:0] as_in;
    logic [IW-1:0]         b_in;
    logic                  c_in;
    logic                  sub_in;
    logic                  v_in;

    logic [STG_WIDTH:0]    slice_sum;
    logic [DATA_WIDTH-1:0] as_nxt;
    logic                  c_nxt;

    logic [DATA_WIDTH-1:0] as_q;
    logic                  c_q;
    logic                  v_q;

    if (k == 0) begin : g_src
      assign as_in  = adda;
      assign b_in   = i_sub ? ~addb : addb;
      assign c_in   = i_sub;
      assign sub_in = i_sub;
      assign v_in   = i_en;
    end else begin : g_src
      assign as_in  = g_stg[k-1].as_q;
      assign b_in   = g_stg[k-1].g_fwd.b_q;
      assign c_in   = g_stg[k-1].c_q;
      assign sub_in = g_stg[k-1].g_fwd.sub_q;
      assign v_in   = g_stg[k-1].v_q;
    end

    assign slice_sum = {1'b0, as_in[k*STG_WIDTH +: STG_WIDTH]}
                     + {1'b0, b_in[STG_WIDTH-1:0]}
                     + {{STG_WIDTH{1'b0}}, c_in};

    // The last stage stores the carry already converted to a borrow for
    // subtracts, so result is a pure register with no logic behind it.
    assign c_nxt = LAST ? (slice_sum[STG_WIDTH] ^ sub_in) : slice_sum[STG_WIDTH];

    // NOTE: every variable gets a full default before the partial overwrite;
    // a path that leaves bits unassigned in always_comb infers a latch.
    always_comb begin
      as_nxt = as_in;
      as_nxt[k*STG_WIDTH +: STG_WIDTH] = slice_sum[STG_WIDTH-1:0];
    end

    // NOTE: the data registers are reset too, not just the valids, because
    // result must read as zero during reset; without that they could skip it.
    // NOTE: non-blocking assignments here so every stage samples its
    // neighbour's pre-edge value; blocking would collapse the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        as_q <= '0;
        c_q  <= 1'b0;
        v_q  <= 1'b0;
      end else if (!i_stall) begin
        as_q <= as_nxt;
        c_q  <= c_nxt;
        v_q  <= v_in;
      end
    end

    // Remaining B slices and the mode bit are only needed by later stages.
    if (!LAST) begin : g_fwd
      logic [IW-STG_WIDTH-1:0] b_q;
      logic                    sub_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          b_q   <= '0;
          sub_q <= 1'b0;
        end else if (!i_stall) begin
          b_q   <= b_in[IW-1:STG_WIDTH];
          sub_q <= sub_in;
        end
      end
    end
  end

  assign result = {g_stg[NUM_STG-1].c_q, g_stg[NUM_STG-1].as_q};
  assign o_en   = g_stg[NUM_STG-1].v_q;

endmodule

// File: doc/addsub_pipe_param.md
ADDSUB_PIPE_PARAM -- requirements
Module: addsub_pipe_param

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, 64, operand width in bits.
REQ-002 SHALL have parameter: STG_WIDTH, 16, bits added per pipeline stage.
REQ-003 SHALL have the derived constant NUM_STG = DATA_WIDTH/STG_WIDTH; DATA_WIDTH not an integer multiple of STG_WIDTH, or NUM_STG < 2, is an elaboration error.
REQ-004 SHALL have port: clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port: i_en  input  1  input sample valid.
REQ-007 SHALL have port: i_sub  input  1  per-sample mode: 0 = add, 1 = subtract.
REQ-008 SHALL have port: i_stall  input  1  freeze the whole pipeline for this cycle.
REQ-009 SHALL have port: adda  input  DATA_WIDTH  operand A, unsigned.
REQ-010 SHALL have port: addb  input  DATA_WIDTH  operand B, unsigned.
REQ-011 SHALL have port: result  output  DATA_WIDTH+1  registered result, MSB = carry/borrow.
REQ-012 SHALL have port: o_en  output  1  result valid, registered.

Function
REQ-013 SHALL implement a carry-chained pipeline.
- Stage k (k = 0..NUM_STG-1) adds slice k of the operands plus the registered carry from stage k-1.
- Stage 0 carry-in is i_sub.
- For i_sub = 1, B is inverted on entry.
- Unprocessed operand slices and completed sum slices are delay-matched in registers.
REQ-014 SHALL give add result = {carry_out, (adda+addb) mod 2^DATA_WIDTH}, exactly equal to the (DATA_WIDTH+1)-bit sum.
REQ-015 SHALL give subtract result = {borrow, (adda-addb) mod 2^DATA_WIDTH}, with borrow = 1 iff adda < addb (inverted final carry).
REQ-016 SHALL have latency of exactly NUM_STG enabled clock edges from input capture to result/o_en, i.e. 4 cycles at defaults.
REQ-017 SHALL accept a new sample every non-stalled cycle (throughput 1/cycle); the mode bit travels with its sample, so add and sub may alternate back-to-back.
REQ-018 SHALL propagate a valid bit alongside each stage; o_en = valid of the last stage, and bubbles (i_en = 0) produce o_en = 0 in the matching output cycle.
REQ-019 SHALL keep result value undefined-but-stable when o_en = 0 (no checking required), and SHALL NOT zero it.
REQ-020 SHALL, while i_stall = 1, leave every pipeline register, including the valids, result and o_en, unchanged; adda/addb/i_sub/i_en are not captured that cycle.
REQ-021 SHALL, on i_stall deassertion, resume with no lost, duplicated or reordered samples.
REQ-022 SHALL give i_stall priority over i_en; i_en while stalled is ignored and must be re-presented by the source.
REQ-023 SHALL not affect a bubble's timing through the carry chain; a carry is never propagated from one sample into the next.

Reset
REQ-024 SHALL, while rst_n = 0, asynchronously clear all pipeline registers: result = 0, o_en = 0, all stage valids and carries = 0.
REQ-025 SHALL discard all in-flight samples on reset assertion mid-operation; the first o_en after release occurs exactly NUM_STG non-stalled cycles after the first captured i_en.
REQ-026 SHALL, on the first rising clk edge with rst_n = 1, capture inputs normally; i_stall and i_en are ignored while in reset.

Verification
REQ-027 SHALL be verified by: single add, adda = 64'hFFFF_FFFF_FFFF_FFFF, addb = 1, i_sub = 0 -> o_en = 1 four cycles later, result = 65'h1_0000_0000_0000_0000 (full carry ripple).
REQ-028 SHALL be verified by: single sub, adda = 5, addb = 7, i_sub = 1 -> result = {1'b1, 64'hFFFF_FFFF_FFFF_FFFE}; adda = 7, addb = 5 -> result = {1'b0, 64'd2}.
REQ-029 SHALL be verified by: 100 back-to-back random samples with random i_sub, i_en held high -> o_en continuous from cycle 4 to 103, each result matching a 4-deep golden model in order.
REQ-030 SHALL be verified by: random i_en bubbles plus random i_stall (~30 %) -> output sequence equals input sequence with bubbles preserved; result/o_en frozen in every stalled cycle.
REQ-031 SHALL be verified by: rst_n pulsed low with 3 samples in flight -> o_en = 0 and result = 0 immediately (async), no stale sample ever emitted afterwards.
REQ-032 SHALL be verified by: re-run of REQ-027..REQ-029 with DATA_WIDTH = 32, STG_WIDTH = 8 -> latency 4; and with DATA_WIDTH = 48, STG_WIDTH = 8 -> latency 6.
